// File: rtl/audio_frame_serializer_pkg.sv
// Shared types and sizing helpers for the audio frame serializer family.
package audio_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Width of a counter/select able to address n items; never narrower than 1 bit.
  function automatic int width_of(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Sizes of the default two-channel 16-bit configuration.
  localparam int DEF_DATA_W     = 16;
  localparam int DEF_CHANNELS   = 2;
  localparam int DEF_FRAME_BITS = DEF_CHANNELS * DEF_DATA_W;
  localparam int DEF_CH_W       = width_of(DEF_CHANNELS);
  localparam int DEF_BIT_W      = width_of(DEF_DATA_W);

endpackage

// File: rtl/audio_frame_serializer_if.sv
// Frame source handshake: the source drives a whole frame plus valid, the
// serializer answers with ready when its holding buffer is empty.
interface audio_frame_serializer_if #(
  parameter int DATA_W   = 16,
  parameter int CHANNELS = 2
) ();

  logic [CHANNELS*DATA_W-1:0] data_in;
  logic                       data_valid;
  logic                       data_ready;

  modport master (
    output data_in,
    output data_valid,
    input  data_ready
  );

  modport slave (
    input  data_in,
    input  data_valid,
    output data_ready
  );

endinterface

// File: rtl/audio_frame_serializer_tick.sv
// Bit-rate strobe: tick is high for one clock every CLK_DIV clocks.
// clear holds the divider at zero so the first bit gets a full period.
module bit_tick_gen
  import audio_pkg::*;
#(
  parameter int CLK_DIV = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int                 DIV_W   = width_of(CLK_DIV);
  localparam logic [DIV_W-1:0]   DIV_MAX = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_d;

  assign tick = (div_q == DIV_MAX);

  // Next divider value: restart on clear or on the advancing edge.
  always_comb begin
    div_d = div_q;
    if (clear || tick) begin
      div_d = '0;
    end else begin
      div_d = div_q + DIV_W'(1);
    end
  end

  // Divider register.
  always_ff @(posedge clock) begin
    if (reset) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

endmodule

// File: rtl/audio_frame_serializer.sv
// Multi-channel PCM frame serializer: one-deep holding buffer behind a
// valid/ready handshake, frames shifted out on a 1-bit line at CLK_DIV
// clocks per bit, back-to-back reload with no gap, underrun flagging.
module audio_frame_serializer
  import audio_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int CHANNELS   = 2,
  parameter int CLK_DIV    = 1,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          enable,
  audio_frame_serializer_if.slave       src,
  output logic                          audio_data,
  output logic                          audio_enable,
  output logic [width_of(CHANNELS)-1:0] channel_sel,
  output logic [$clog2(DATA_W)-1:0]     bit_count,
  output logic                          done,
  output logic                          underrun
);

  localparam int FRAME_BITS = CHANNELS * DATA_W;
  localparam int CH_W       = width_of(CHANNELS);
  localparam int BIT_W      = $clog2(DATA_W);

  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(CHANNELS - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  state_t                  state_q,    state_d;
  logic                    buf_full_q, buf_full_d;
  logic [FRAME_BITS-1:0]   buf_data_q, buf_data_d;
  logic [FRAME_BITS-1:0]   frame_q,    frame_d;
  logic [CH_W-1:0]         ch_q,       ch_d;
  logic [BIT_W-1:0]        bc_q,       bc_d;
  logic                    done_q,     done_d;
  logic                    underrun_q, underrun_d;

  logic                    tick;
  logic                    tick_clear;
  logic                    load;
  logic [DATA_W-1:0]       word;
  logic [BIT_W-1:0]        bit_idx;
  logic                    line_bit;

  // The divider only runs while shifting, so every frame starts on a fresh bit period.
  assign tick_clear = (state_q == IDLE);

  bit_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clock (clock),
    .reset (reset),
    .clear (tick_clear),
    .tick  (tick)
  );

  // Sequencing: bit/channel advance, frame end handling, reload and buffer fill.
  always_comb begin
    state_d    = state_q;
    buf_full_d = buf_full_q;
    buf_data_d = buf_data_q;
    frame_d    = frame_q;
    ch_d       = ch_q;
    bc_d       = bc_q;
    done_d     = 1'b0;
    underrun_d = 1'b0;
    load       = 1'b0;

    case (state_q)
      IDLE: begin
        if (buf_full_q && enable) begin
          load    = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (tick) begin
          if (bc_q == BIT_LAST) begin
            bc_d = '0;
            if (ch_q == CH_LAST) begin
              ch_d   = '0;
              done_d = 1'b1;
              if (buf_full_q && enable) begin
                load = 1'b1;
              end else begin
                state_d    = IDLE;
                underrun_d = enable;
              end
            end else begin
              ch_d = ch_q + CH_W'(1);
            end
          end else begin
            bc_d = bc_q + BIT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Loading needs a full buffer and accepting needs an empty one, so they never collide.
    if (load) begin
      frame_d    = buf_data_q;
      buf_full_d = 1'b0;
      ch_d       = '0;
      bc_d       = '0;
    end else if (src.data_valid && !buf_full_q) begin
      buf_full_d = 1'b1;
      buf_data_d = src.data_in;
    end
  end

  // Control registers; reset abandons any frame in flight and empties the buffer.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      buf_full_q <= 1'b0;
      ch_q       <= '0;
      bc_q       <= '0;
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_full_q <= buf_full_d;
      ch_q       <= ch_d;
      bc_q       <= bc_d;
      done_q     <= done_d;
      underrun_q <= underrun_d;
    end
  end

  // Frame payload registers; contents are only observed while shifting.
  always_ff @(posedge clock) begin
    buf_data_q <= buf_data_d;
    frame_q    <= frame_d;
  end

  // Pick the active channel word and the bit within it for the serial line.
  always_comb begin
    word = frame_q[DATA_W-1:0];
    for (int k = 0; k < CHANNELS; k++) begin
      if (ch_q == CH_W'(k)) begin
        word = frame_q[k*DATA_W +: DATA_W];
      end
    end
    bit_idx  = MSB_FIRST ? (BIT_LAST - bc_q) : bc_q;
    line_bit = word[0];
    for (int j = 0; j < DATA_W; j++) begin
      if (bit_idx == BIT_W'(j)) begin
        line_bit = word[j];
      end
    end
  end

  assign src.data_ready = !buf_full_q;
  assign audio_enable   = (state_q == SHIFT);
  assign audio_data     = (state_q == SHIFT) ? line_bit : IDLE_LEVEL;
  assign channel_sel    = ch_q;
  assign bit_count      = bc_q;
  assign done           = done_q;
  assign underrun       = underrun_q;

endmodule

// File: tb/tb_audio_frame_serializer.sv
// Bench for audio_frame_serializer: three configurations run side by side
// (1ch/div1/MSB, 2ch/div4/MSB, 1ch/div1/LSB with idle-high line), each
// checked every cycle against a frame-position model of the serial line.
module tb_audio_frame_serializer;

  localparam int N = 3;

  function automatic int p_ch(input int g);
    return (g == 1) ? 2 : 1;
  endfunction
  function automatic int p_div(input int g);
    return (g == 1) ? 4 : 1;
  endfunction
  function automatic bit p_msb(input int g);
    return (g != 2);
  endfunction
  function automatic bit p_idle(input int g);
    return (g == 2);
  endfunction

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst [N];
  logic        en  [N];
  logic        vld [N];
  logic [63:0] din [N];
  logic        rdy [N];
  logic        ad  [N];
  logic        ae  [N];
  logic        chs [N];
  logic [3:0]  bcs [N];
  logic        dn  [N];
  logic        ur  [N];

  for (genvar g = 0; g < N; g++) begin : gd
    localparam int CH = p_ch(g);
    audio_frame_serializer_if #(.DATA_W(16), .CHANNELS(CH)) sif ();
    assign sif.data_in    = din[g][CH*16-1:0];
    assign sif.data_valid = vld[g];
    assign rdy[g]         = sif.data_ready;
    audio_frame_serializer #(
      .DATA_W     (16),
      .CHANNELS   (CH),
      .CLK_DIV    (p_div(g)),
      .MSB_FIRST  (p_msb(g)),
      .IDLE_LEVEL (p_idle(g))
    ) dut (
      .clock        (clk),
      .reset        (rst[g]),
      .enable       (en[g]),
      .src          (sif),
      .audio_data   (ad[g]),
      .audio_enable (ae[g]),
      .channel_sel  (chs[g]),
      .bit_count    (bcs[g]),
      .done         (dn[g]),
      .underrun     (ur[g])
    );
  end

  // Reference model: where we are in the current frame, measured in clocks.
  typedef struct {
    bit          active;
    int          pos;
    logic [63:0] frame;
    bit          bfull;
    logic [63:0] bdat;
    bit          done;
    bit          und;
  } mdl_t;

  mdl_t        m [N];
  logic [63:0] srcq [N][$];
  int          done_cnt [N];
  int          und_cnt  [N];
  int          total = 0;
  int          bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input int i);
    bit take;
    int len;
    len = p_ch(i) * 16 * p_div(i);
    if (rst[i]) begin
      m[i].active = 0; m[i].pos = 0; m[i].bfull = 0; m[i].done = 0; m[i].und = 0;
      return;
    end
    take      = vld[i] && !m[i].bfull;
    m[i].done = 0;
    m[i].und  = 0;
    if (m[i].active) begin
      m[i].pos++;
      if (m[i].pos == len) begin
        m[i].done = 1;
        if (m[i].bfull && en[i]) begin
          m[i].frame = m[i].bdat; m[i].bfull = 0; m[i].pos = 0;
        end else begin
          m[i].active = 0; m[i].pos = 0; m[i].und = en[i];
        end
      end
    end else if (m[i].bfull && en[i]) begin
      m[i].active = 1; m[i].pos = 0; m[i].frame = m[i].bdat; m[i].bfull = 0;
    end
    if (take) begin
      m[i].bfull = 1; m[i].bdat = din[i];
    end
  endtask

  task automatic check_dut(input int i);
    int bn, ch, k, idx;
    logic e_ad;
    e_ad = p_idle(i);
    ch = 0; k = 0;
    if (m[i].active) begin
      bn   = m[i].pos / p_div(i);
      ch   = bn / 16;
      k    = bn % 16;
      idx  = p_msb(i) ? 15 - k : k;
      e_ad = m[i].frame[ch*16 + idx];
    end
    chk($sformatf("ready%0d", i),    64'(rdy[i]), 64'(!m[i].bfull));
    chk($sformatf("aen%0d", i),      64'(ae[i]),  64'(m[i].active));
    chk($sformatf("adata%0d", i),    64'(ad[i]),  64'(e_ad));
    chk($sformatf("chsel%0d", i),    64'(chs[i]), 64'(ch));
    chk($sformatf("bitcnt%0d", i),   64'(bcs[i]), 64'(k));
    chk($sformatf("done%0d", i),     64'(dn[i]),  64'(m[i].done));
    chk($sformatf("underrun%0d", i), 64'(ur[i]),  64'(m[i].und));
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      vld[i] = (srcq[i].size() > 0);
      din[i] = vld[i] ? srcq[i][0] : {$urandom(), $urandom()};
    end
  endtask

  task automatic cycle();
    bit take [N];
    for (int i = 0; i < N; i++) take[i] = vld[i] && rdy[i] && !rst[i];
    @(posedge clk);
    for (int i = 0; i < N; i++) model_step(i);
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (take[i]) void'(srcq[i].pop_front());
      check_dut(i);
      done_cnt[i] += int'(dn[i]);
      und_cnt[i]  += int'(ur[i]);
    end
  endtask

  task automatic step();
    drive();
    cycle();
  endtask

  initial begin
    int k;
    for (int i = 0; i < N; i++) begin
      m[i].active = 0; m[i].pos = 0; m[i].bfull = 0; m[i].done = 0; m[i].und = 0;
      m[i].frame = '0; m[i].bdat = '0;
      rst[i] = 1'b1; en[i] = 1'b1; done_cnt[i] = 0; und_cnt[i] = 0;
    end
    srcq[0].push_back(64'h0000_0000_0000_A5AF);
    srcq[1].push_back(64'h0000_0000_0000_FFFF);
    srcq[1].push_back(64'h0000_0000_FFFF_0000);
    srcq[2].push_back(64'h0000_0000_0000_0001);

    // Reset held with valid asserted: nothing may be taken.
    repeat (3) step();
    for (int i = 0; i < N; i++) rst[i] = 1'b0;

    // Directed frames; dut1 drops enable during its second frame so it ends without underrun.
    repeat (150) step();
    en[1] = 1'b0;
    repeat (150) step();
    chk("done_cnt0", 64'(done_cnt[0]), 64'd1);
    chk("und_cnt0",  64'(und_cnt[0]),  64'd1);
    chk("done_cnt1", 64'(done_cnt[1]), 64'd2);
    chk("und_cnt1",  64'(und_cnt[1]),  64'd0);
    chk("done_cnt2", 64'(done_cnt[2]), 64'd1);
    chk("und_cnt2",  64'(und_cnt[2]),  64'd1);

    // Enable dropped at bit 5 with the next frame buffered.
    en[1] = 1'b1;
    srcq[1].push_back({$urandom(), $urandom()});
    srcq[1].push_back({$urandom(), $urandom()});
    for (k = 0; k < 400; k++) begin
      if (ae[1] && bcs[1] == 4'd5) break;
      step();
    end
    chk("wait_bit5", 64'(k < 400), 64'd1);
    en[1] = 1'b0;
    repeat (300) step();
    chk("hold_ready1", 64'(rdy[1]), 64'd0);
    chk("hold_aen1",   64'(ae[1]),  64'd0);
    en[1] = 1'b1;
    for (k = 0; k < 10; k++) begin
      if (ae[1]) break;
      step();
    end
    chk("restart1", 64'(k < 10), 64'd1);
    repeat (300) step();

    // Reset in the middle of a frame.
    srcq[0].push_back({$urandom(), $urandom()});
    srcq[0].push_back({$urandom(), $urandom()});
    for (k = 0; k < 100; k++) begin
      if (ae[0] && bcs[0] == 4'd8) break;
      step();
    end
    chk("wait_bit8", 64'(k < 100), 64'd1);
    rst[0] = 1'b1;
    step();
    rst[0] = 1'b0;
    chk("rst_aen0",   64'(ae[0]),  64'd0);
    chk("rst_ready0", 64'(rdy[0]), 64'd1);
    chk("rst_done0",  64'(dn[0]),  64'd0);
    repeat (60) step();

    // Randomized traffic, enable toggling and occasional resets.
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < N; i++) begin
        rst[i] = ($urandom_range(0, 499) == 0);
        if ($urandom_range(0, 39) == 0) en[i] = ~en[i];
        if (srcq[i].size() < 2 && $urandom_range(0, 3) == 0)
          srcq[i].push_back({$urandom(), $urandom()});
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
